adder_serial_nbit: RTL and testbench
====================================

Name: adder_serial_nbit

Overview:
- Bit-serial N-bit adder; the clocked stage directly downstream of the 1-bit half-adder cells.
- Each cycle it steps one operand bit pair, LSB first, through a full-add slice (two adder_half_1bit instances plus an OR on the carries).
- A carry flip-flop holds the carry between bits, and the sum is shifted into a result register.
- Used where area matters more than latency; start/busy/done handshake towards the controlling logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset; clears all state immediately on assertion, synchronous release assumed by system
start  input  1  request; sampled on rising edge when state is IDLE or DONE
operand_a  input  WIDTH  addend A; sampled only on the edge that accepts start
operand_b  input  WIDTH  addend B; sampled only on the edge that accepts start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result, registered; holds value until next accepted start
carry_out  output  1  final carry, registered; holds with sum

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, carry_out=0, bit counter=0, carry flip-flop=0, shift registers=0.
- A reset asserted mid-RUN aborts the operation with no partial result kept.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accepting start (edge E0, start=1, state IDLE or DONE):
  - load operand_a/operand_b into shift registers A_sr/B_sr;
  - clear the carry flip-flop and counter;
  - go to RUN.
- Each RUN edge:
  - s = A_sr[0]^B_sr[0]^c;
  - c' = (A_sr[0]&B_sr[0]) | (c&(A_sr[0]^B_sr[0]));
  - shift s into result MSB (result shifts right);
  - shift A_sr/B_sr right by one;
  - counter+1.
- Exit from RUN: when counter reaches WIDTH-1 on a RUN edge, that edge completes the last bit and moves to DONE. sum = full result; carry_out = final c.
- Latency: bit i is processed on edge E(i+1). DONE is entered after edge E(WIDTH), so done is high in the cycle between E(WIDTH) and E(WIDTH+1).
- DONE, start=0: go to IDLE at next edge.
- DONE, start=1: accept as new start (back-to-back); done drops and busy rises after that edge.
- start while RUN: ignored; operands not resampled.
- sum/carry_out behaviour:
  - change only on the edge entering DONE or on reset;
  - not updated during RUN (the internal shift register is separate from the sum port);
  - on acceptance of a new start, sum/carry_out keep the previous result until the new DONE.
- Arithmetic: {carry_out,sum} = operand_a + operand_b (+ carry_in if enabled), modulo 2^(WIDTH+1). No overflow beyond carry_out.
- WIDTH=1: a single RUN cycle; done after E1.

Optional Feature:
- Macro ADDER_SERIAL_CARRY_IN_EN.
- Defined: adds port carry_in (input, 1 bit), sampled with operands on the accepting edge; it initialises the carry flip-flop. The result is operand_a+operand_b+carry_in.
- Undefined: port absent; carry flip-flop initialised to 0.

Test Plan:
1. WIDTH=8, A=0x5A, B=0x3C, start one cycle -> busy high 8 cycles; done pulse exactly one cycle after 8th RUN edge; sum=0x96, carry_out=0.
2. A=0xFF, B=0x01 -> sum=0x00, carry_out=1. Then hold start=0 10 cycles -> sum/carry_out unchanged, done stays 0.
3. Start A=0x12, B=0x34; at RUN cycle 3 drive start=1 with A=0xFF, B=0xFF -> ignored; result sum=0x46, carry_out=0.
4. Start A=0xAA, B=0x55; pull reset_n low at RUN cycle 4 (between edges) -> busy/done/sum/carry_out go 0 immediately. After release, start A=0x01, B=0x01 -> sum=0x02.
5. Back-to-back: start held high through DONE; A=0x80, B=0x80 then A=0x0F, B=0xF0:
   - first done -> sum=0x00, carry_out=1;
   - busy re-asserts the next cycle; second done -> sum=0xFF, carry_out=0;
   - no IDLE cycle in between.
6. ADDER_SERIAL_CARRY_IN_EN defined, A=0xFF, B=0x00, carry_in=1 -> sum=0x00, carry_out=1. Same operands with carry_in=0 -> sum=0xFF, carry_out=0.

Source files
------------

// File: rtl/adder_serial_nbit.sv
// Bit-serial N-bit adder: one operand bit pair per clock, LSB first, with start/busy/done handshake.
// Define ADDER_SERIAL_CARRY_IN_EN to add a carry_in port that seeds the carry flip-flop.

module adder_half_1bit (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module adder_serial_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
`ifdef ADDER_SERIAL_CARRY_IN_EN
    input  logic             carry_in,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             cin_init;

    logic s1, c1, s_bit, c2, c_next;

`ifdef ADDER_SERIAL_CARRY_IN_EN
    assign cin_init = carry_in;
`else
    assign cin_init = 1'b0;
`endif

    adder_half_1bit u_ha0 (.a(a_sr_q[0]), .b(b_sr_q[0]), .s(s1),    .c(c1));
    adder_half_1bit u_ha1 (.a(s1),        .b(c_q),       .s(s_bit), .c(c2));
    assign c_next = c1 | c2;

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sr_d  = operand_a;
                    b_sr_d  = operand_b;
                    res_d   = '0;
                    cnt_d   = '0;
                    c_d     = cin_init;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                // Bit i lands at position i: same end state as shifting s in at the MSB WIDTH times.
                res_d[cnt_q] = s_bit;
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    sum_d   = res_d;
                    cout_d  = c_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Self-checking bench for adder_serial_nbit: directed cases plus randomized operands
// compared against plain integer addition.

module tb_adder_serial_nbit;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         cin = 1'b0;
    logic         busy, done, carry_out;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;
    logic [W:0] prev_res = '0;

    always #5 clock = ~clock;

    adder_serial_nbit #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .operand_a(operand_a), .operand_b(operand_b),
`ifdef ADDER_SERIAL_CARRY_IN_EN
        .carry_in(cin),
`endif
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int unsigned t;
        t = int'(a) + int'(b);
`ifdef ADDER_SERIAL_CARRY_IN_EN
        t = t + int'(ci);
`endif
        return t[W:0];
    endfunction

    // Issue one operation and follow it to done. Inputs change on negedges only.
    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input bit keep_start);
        int n;
        logic [W:0] exp;
        exp = model(a, b, ci);
        operand_a = a; operand_b = b; cin = ci; start = 1'b1;
        @(negedge clock);
        if (!keep_start) start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_done_low"}, done, 0);
        n = 0;
        while (busy && n < 100) begin
            if (n == 3) chk({tag, "_sum_hold"}, {carry_out, sum}, prev_res);
            n++;
            @(negedge clock);
        end
        chk({tag, "_busy_cycles"}, n, W);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_result"}, {carry_out, sum}, exp);
        prev_res = exp;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", {carry_out, sum}, 0);
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
        chk("idle_busy", busy, 0);

        do_add("t1", 8'h5A, 8'h3C, 1'b0, 1'b0);
        chk("t1_sum", sum, 8'h96);
        @(negedge clock);
        chk("t1_done_pulse", done, 0);

        do_add("t2", 8'hFF, 8'h01, 1'b0, 1'b0);
        chk("t2_cout", carry_out, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t2_hold_done", done, 0);
            chk("t2_hold_res", {carry_out, sum}, 9'h100);
        end

        // start during RUN must be ignored
        operand_a = 8'h12; operand_b = 8'h34; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        operand_a = 8'hFF; operand_b = 8'hFF; start = 1'b1;
        @(negedge clock); start = 1'b0;
        begin
            int n = 0;
            while (!done && n < 40) begin n++; @(negedge clock); end
            chk("t3_done_seen", done, 1);
        end
        chk("t3_result", {carry_out, sum}, 9'h046);
        prev_res = 9'h046;
        @(negedge clock);

        // async reset mid-run
        operand_a = 8'hAA; operand_b = 8'h55; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_result", {carry_out, sum}, 0);
        @(negedge clock); reset_n = 1'b1;
        prev_res = '0;
        do_add("t4b", 8'h01, 8'h01, 1'b0, 1'b0);
        chk("t4b_sum", sum, 8'h02);
        @(negedge clock);

        // back-to-back with start held
        do_add("t5a", 8'h80, 8'h80, 1'b0, 1'b1);
        do_add("t5b", 8'h0F, 8'hF0, 1'b0, 1'b0);
        chk("t5b_sum", sum, 8'hFF);
        @(negedge clock);

`ifdef ADDER_SERIAL_CARRY_IN_EN
        do_add("t6a", 8'hFF, 8'h00, 1'b1, 1'b0);
        chk("t6a_res", {carry_out, sum}, 9'h100);
        @(negedge clock);
        do_add("t6b", 8'hFF, 8'h00, 1'b0, 1'b0);
        chk("t6b_res", {carry_out, sum}, 9'h0FF);
        @(negedge clock);
`endif

        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            do_add("rnd", ra, rb, rc, ($urandom_range(0, 2) == 0));
            if (start) begin
                start = 1'b0;
            end else begin
                @(negedge clock);
                chk("rnd_idle", done, 0);
            end
            @(negedge clock);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
